// File: rtl/branch_resolve_unit.sv
// Purpose : EX-stage branch resolution; queues fetch predictions, checks them on resolve,
//           drives predictor update, pipeline flush and PC redirect on mispredict.
// Latency : resolve outputs (Upd_*, Redirect_*) are registered, one cycle after the pop.
// Backpr. : Queue_Full (combinational) tells fetch to stall; Stall_Detected freezes push/pop.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   Pred_Valid/Pred_Taken/Pred_PC   prediction issued at fetch (push)
//   Stall_Detected                  pipeline stall, blocks push and pop
//   Res_Valid/Res_Taken/Res_Target  oldest in-flight branch resolved in EX (pop)
//   Upd_Valid/Upd_Taken             predictor update strobe and actual outcome
//   Flush                           squash IF/ID for FLUSH_CYCLES cycles
//   Redirect_Valid/Redirect_PC      one-cycle corrected fetch PC
//   Queue_Full                      prediction queue holds Q_DEPTH entries
//   Err_Underflow                   sticky: resolve seen with an empty queue
// Optional feature macro: PERF_COUNTERS_EN adds saturating Br_Count / Mispred_Count outputs.

module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int Q_DEPTH      = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Pred_Valid,
  input  logic              Pred_Taken,
  input  logic [XLEN-1:0]   Pred_PC,
  input  logic              Stall_Detected,
  input  logic              Res_Valid,
  input  logic              Res_Taken,
  input  logic [XLEN-1:0]   Res_Target,
  output logic              Upd_Valid,
  output logic              Upd_Taken,
  output logic              Flush,
  output logic              Redirect_Valid,
  output logic [XLEN-1:0]   Redirect_PC,
  output logic              Queue_Full,
  output logic              Err_Underflow
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]  Br_Count,
  output logic [CNT_W-1:0]  Mispred_Count
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CQ_W  = PTR_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES) + 1;

  localparam logic [CQ_W-1:0] DEPTH_C    = CQ_W'(Q_DEPTH);
  localparam logic [FC_W-1:0] FC_LOAD_C  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] INSN_SZ_C  = XLEN'(4);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Queue storage and bookkeeping
  entry_t            q_mem [Q_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CQ_W-1:0]   count_q, count_d;

  // FSM
  state_t            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;

  // Registered resolve outputs
  logic              upd_valid_q, upd_valid_d;
  logic              upd_taken_q, upd_taken_d;
  logic              redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              err_q, err_d;

  // Datapath strobes
  logic              q_full;
  logic              q_empty;
  logic              pop;
  logic              push;
  logic              push_wr;
  logic              underflow_evt;
  logic              mispred;
  logic              redirect;
  entry_t            head;
  entry_t            wr_ent;

  assign q_full        = (count_q == DEPTH_C);
  assign q_empty       = (count_q == '0);
  assign head          = q_mem[rd_ptr_q];

  assign pop           = Res_Valid & ~Stall_Detected & ~q_empty;
  assign underflow_evt = Res_Valid & ~Stall_Detected &  q_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push          = Pred_Valid & ~Stall_Detected & (state_q == ST_IDLE) & (~q_full | pop);
  assign mispred       = pop & (head.taken != Res_Taken);
  // Only an IDLE mispredict redirects; pops during FLUSH just update the predictor.
  assign redirect      = mispred & (state_q == ST_IDLE);
  // A push that coincides with the redirect belongs to the squashed path.
  assign push_wr       = push & ~redirect;

  assign wr_ent.taken  = Pred_Taken;
  assign wr_ent.pc     = Pred_PC;

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // FSM: next state and outputs. The flush counter runs every cycle,
  // stalls do not stretch the flush window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    Flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_LOAD_C;
        end
      end
      ST_FLUSH: begin
        Flush = 1'b1;
        if (fcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Queue pointer / occupancy next state
  // ---------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CQ_W'(push) - CQ_W'(pop);
    if (redirect) begin
      // Everything still queued is younger than the mispredicted branch.
      count_d  = '0;
      wr_ptr_d = rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_wr) begin
      q_mem[wr_ptr_q] <= wr_ent;
    end
  end

  // ---------------------------------------------------------------
  // Resolve outputs
  // ---------------------------------------------------------------
  always_comb begin
    upd_valid_d   = pop;
    upd_taken_d   = pop & Res_Taken;
    redir_valid_d = redirect;
    redir_pc_d    = redir_pc_q;
    err_d         = err_q | underflow_evt;
    if (redirect) begin
      // Fall-through wraps naturally at XLEN bits.
      redir_pc_d = Res_Taken ? Res_Target : (head.pc + INSN_SZ_C);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      err_q         <= err_d;
    end
  end

  assign Upd_Valid      = upd_valid_q;
  assign Upd_Taken      = upd_taken_q;
  assign Redirect_Valid = redir_valid_q;
  assign Redirect_PC    = redir_pc_q;
  assign Queue_Full     = q_full;
  assign Err_Underflow  = err_q;

`ifdef PERF_COUNTERS_EN
  // ---------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (pop && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispred && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign Br_Count      = br_cnt_q;
  assign Mispred_Count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose : self-checking bench for branch_resolve_unit (default parameters).
// Latency : resolve results are expected one cycle after the pop is driven.
// Backpr. : a reference queue model decides push acceptance, drops and flush clearing.

module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int QD      = 4;
  localparam int FC      = 2;
  localparam int CNT_W   = 16;

  logic              clk;
  logic              rst_n;
  logic              Pred_Valid;
  logic              Pred_Taken;
  logic [XLEN-1:0]   Pred_PC;
  logic              Stall_Detected;
  logic              Res_Valid;
  logic              Res_Taken;
  logic [XLEN-1:0]   Res_Target;
  logic              Upd_Valid;
  logic              Upd_Taken;
  logic              Flush;
  logic              Redirect_Valid;
  logic [XLEN-1:0]   Redirect_PC;
  logic              Queue_Full;
  logic              Err_Underflow;
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0]  Br_Count;
  logic [CNT_W-1:0]  Mispred_Count;
`endif

  branch_resolve_unit #(
    .XLEN(XLEN), .Q_DEPTH(QD), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Pred_Valid(Pred_Valid), .Pred_Taken(Pred_Taken), .Pred_PC(Pred_PC),
    .Stall_Detected(Stall_Detected),
    .Res_Valid(Res_Valid), .Res_Taken(Res_Taken), .Res_Target(Res_Target),
    .Upd_Valid(Upd_Valid), .Upd_Taken(Upd_Taken), .Flush(Flush),
    .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
    .Queue_Full(Queue_Full), .Err_Underflow(Err_Underflow)
`ifdef PERF_COUNTERS_EN
    , .Br_Count(Br_Count), .Mispred_Count(Mispred_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef struct { logic t; logic [XLEN-1:0] pc; } ent_t;
  typedef struct { logic taken; logic rv; logic [XLEN-1:0] rpc; } exp_t;
  ent_t mq[$];
  exp_t sb[$];
  bit   m_idle;
  int   m_fcnt;
  bit   m_err;
  int   m_br;
  int   m_mis;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_idle = 1'b1;
    m_fcnt = 0;
    m_err  = 1'b0;
    m_br   = 0;
    m_mis  = 0;
  endtask

  task automatic drive_idle();
    Pred_Valid = 0; Pred_Taken = 0; Pred_PC = '0; Stall_Detected = 0;
    Res_Valid = 0; Res_Taken = 0; Res_Target = '0;
  endtask

  // Check outputs produced by the previous edge, then drive this cycle and
  // advance the model to the state expected after the next edge.
  task automatic step(input bit pv, input bit pt, input logic [XLEN-1:0] ppc,
                      input bit st, input bit rv, input bit rt, input logic [XLEN-1:0] tgt);
    exp_t e;
    ent_t h;
    bit   pop, push, mis, redir;
    @(negedge clk);
    if (Upd_Valid) begin
      if (sb.size() == 0) begin
        check_val("upd_spurious", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("upd_taken", Upd_Taken, e.taken);
        check_val("redir_vld", Redirect_Valid, e.rv);
        if (e.rv) check_val("redir_pc", Redirect_PC, e.rpc);
      end
    end else begin
      if (sb.size() != 0) begin
        check_val("upd_missing", 0, 1);
        void'(sb.pop_front());
      end
      if (Redirect_Valid) check_val("redir_spurious", 1, 0);
    end
    check_val("flush", Flush, !m_idle);
    check_val("queue_full", Queue_Full, mq.size() == QD);
    check_val("err_underflow", Err_Underflow, m_err);
`ifdef PERF_COUNTERS_EN
    check_val("br_count", Br_Count, m_br);
    check_val("mispred_count", Mispred_Count, m_mis);
`endif
    Pred_Valid = pv; Pred_Taken = pt; Pred_PC = ppc; Stall_Detected = st;
    Res_Valid = rv; Res_Taken = rt; Res_Target = tgt;

    pop   = rv && !st && (mq.size() != 0);
    push  = pv && !st && m_idle && ((mq.size() < QD) || pop);
    redir = 1'b0;
    if (rv && !st && mq.size() == 0) m_err = 1'b1;
    if (pop) begin
      h     = mq.pop_front();
      mis   = (h.t != rt);
      redir = mis && m_idle;
      e.taken = rt;
      e.rv    = redir;
      e.rpc   = rt ? tgt : h.pc + 32'd4;
      sb.push_back(e);
      m_br++;
      if (mis) m_mis++;
    end
    if (push) begin
      h.t  = pt;
      h.pc = ppc;
      mq.push_back(h);
    end
    if (!m_idle) begin
      if (m_fcnt == 0) m_idle = 1'b1;
      else m_fcnt--;
    end else if (redir) begin
      mq.delete();
      m_idle = 1'b0;
      m_fcnt = FC - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, '0);
  endtask

  // Asynchronous reset between clock edges: outputs must clear immediately.
  task automatic async_reset_check();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_upd_valid", Upd_Valid, 0);
    check_val("rst_upd_taken", Upd_Taken, 0);
    check_val("rst_flush", Flush, 0);
    check_val("rst_redir_vld", Redirect_Valid, 0);
    check_val("rst_redir_pc", Redirect_PC, 0);
    check_val("rst_queue_full", Queue_Full, 0);
    check_val("rst_err", Err_Underflow, 0);
`ifdef PERF_COUNTERS_EN
    check_val("rst_br_count", Br_Count, 0);
    check_val("rst_mis_count", Mispred_Count, 0);
`endif
    model_reset();
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit pv, pt, st, rv, rt;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_val("init_upd_valid", Upd_Valid, 0);
    check_val("init_flush", Flush, 0);
    check_val("init_redir_pc", Redirect_PC, 0);
    rst_n = 1'b1;
    idle(2);

    // Correct prediction, taken
    step(1, 1, 32'h100, 0, 0, 0, '0);
    step(0, 0, '0,      0, 1, 1, 32'h500);
    idle(2);

    // Predicted taken, actually not taken -> fall-through redirect, flush
    step(1, 1, 32'h200, 0, 0, 0, '0);
    step(0, 0, '0,      0, 1, 0, 32'h900);
    idle(4);

`ifdef PERF_COUNTERS_EN
    check_val("perf_br_after_t3", Br_Count, 2);
    check_val("perf_mis_after_t3", Mispred_Count, 1);
`endif

    // Predicted not taken, actually taken -> target redirect
    step(1, 0, 32'h300, 0, 0, 0, '0);
    step(0, 0, '0,      0, 1, 1, 32'h400);
    idle(4);

    // Fill, overflow drop, push+pop while full, stall freeze, drain
    for (int i = 0; i < QD; i++) step(1, 1, 32'h10 + 4 * i, 0, 0, 0, '0);
    step(1, 1, 32'h80, 0, 0, 0, '0);
    step(1, 1, 32'h84, 0, 1, 1, 32'h1000);
    step(1, 0, 32'h88, 1, 1, 0, 32'h2000);
    step(0, 0, '0,     1, 1, 0, 32'h2000);
    for (int i = 0; i < QD; i++) step(0, 0, '0, 0, 1, 1, 32'h3000);
    idle(2);

    // Mispredict while full with a simultaneous push: queue cleared, push discarded
    for (int i = 0; i < QD; i++) step(1, 0, 32'h40 + 4 * i, 0, 0, 0, '0);
    step(1, 0, 32'h60, 0, 1, 1, 32'h7000);
    step(0, 0, '0,     0, 1, 0, '0);
    idle(4);

    // Underflow: sticky error
    step(0, 0, '0, 0, 1, 0, '0);
    idle(5);

    // Wrap edge: fall-through past the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 0, 0, 0, '0);
    step(0, 0, '0, 0, 1, 0, '0);
    idle(4);

    // Mid-flush asynchronous reset
    step(1, 1, 32'h500, 0, 0, 0, '0);
    step(1, 1, 32'h504, 0, 0, 0, '0);
    step(0, 0, '0,      0, 1, 0, '0);
    step(0, 0, '0,      0, 0, 0, '0);
    async_reset_check();
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(99) < 55);
      pt = $urandom_range(1);
      st = ($urandom_range(99) < 15);
      rv = ($urandom_range(99) < 45);
      if (mq.size() != 0 && $urandom_range(3) != 0) rt = mq[0].t;
      else rt = $urandom_range(1);
      step(pv, pt, {$urandom} & 32'hFFFF_FFFC, st, rv, rt, {$urandom} & 32'hFFFF_FFFC);
    end
    idle(6);
    check_val("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
